// File: rtl/spi_frame_master.sv
// spi_frame_master: fixed-length SPI mode-0 frame master with csb timing.
// Build option SPI_FRAME_MISO_CAPTURE_EN adds the miso capture path.
module spi_frame_master #(
  parameter int FRAME_W  = 24,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               miso,
  output logic               sclk,
  output logic               csb,
  output logic               mosi,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rx_data
);

  localparam int BW = $clog2(FRAME_W + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_W - 1);
  localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
  localparam logic [7:0]    SETUP_MAX = 8'(CS_SETUP - 1);
  localparam logic [7:0]    HOLD_MAX  = 8'(CS_HOLD - 1);
  localparam logic [7:0]    GAP_MAX   = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] sr;
  logic [BW-1:0]      bit_cnt;
  logic [DW-1:0]      div_cnt;
  logic [7:0]         tmr;

  // csb high gates mosi so the line is quiet between frames
  assign mosi = sr[FRAME_W-1] & ~csb;

  // frame sequencer; sclk itself is the half-period phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      tmr     <= '0;
      sclk    <= 1'b0;
      csb     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= tx_data;
            csb   <= 1'b0;
            busy  <= 1'b1;
            tmr   <= '0;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == SETUP_MAX) begin
            tmr     <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sclk) begin
              sr <= {sr[FRAME_W-2:0], 1'b0};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                tmr     <= '0;
                state   <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        HOLD: begin
          if (tmr == HOLD_MAX) begin
            tmr   <= '0;
            csb   <= 1'b1;
            state <= GAP;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        GAP: begin
          if (tmr == GAP_MAX) begin
            tmr   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_FRAME_MISO_CAPTURE_EN
  logic [FRAME_W-1:0] rx_sr;
  logic               rise;

  assign rise = (state == SHIFT) && (div_cnt == DIV_MAX) && !sclk;

  // shift miso in on each rising sclk, publish together with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sr   <= '0;
      rx_data <= '0;
    end else begin
      if (rise)
        rx_sr <= {rx_sr[FRAME_W-2:0], miso};
      if (state == GAP && tmr == GAP_MAX)
        rx_data <= rx_sr;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: random frames against a bus-level SPI model.
// Also covers back-to-back, ignored start, mid-frame reset, 8-bit build.
module tb_spi_frame_master;

  localparam int W  = 24;
  localparam int CD = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         miso = 1'b0;
  logic         sclk, csb, mosi, busy, done;
  logic [W-1:0] rx_data;

  logic       s_start = 1'b0;
  logic [7:0] s_tx = '0;
  logic       s_sclk, s_csb, s_mosi, s_busy, s_done;
  logic [7:0] s_rx;

  always #5 clk = ~clk;

  spi_frame_master dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .miso(miso), .sclk(sclk), .csb(csb), .mosi(mosi),
    .busy(busy), .done(done), .rx_data(rx_data)
  );

  spi_frame_master #(.FRAME_W(8), .CLK_DIV(1)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .tx_data(s_tx),
    .miso(s_mosi), .sclk(s_sclk), .csb(s_csb), .mosi(s_mosi),
    .busy(s_busy), .done(s_done), .rx_data(s_rx)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_rx(input logic [63:0] w);
`ifdef SPI_FRAME_MISO_CAPTURE_EN
    return w;
`else
    return w & 64'h0;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // bus monitor plus a mode-0 slave that shifts slave_word out on miso
  logic [W-1:0] slave_word = '0;
  logic [W-1:0] cur_mosi = '0, f_mosi = '0;
  int cyc = 0, cur_low = 0, cur_rises = 0, f_low = 0, f_rises = 0;
  int hi = 0, k = 0, last_rise = 0, done_cnt = 0, idle_bad = 0;
  int gap_track = 0, gmin = 999, gmax = 0;
  logic per_ok = 1'b1, f_per = 1'b1;
  logic p_csb = 1'b1, p_sclk = 1'b0;

  always @(negedge clk) begin
    if (csb === 1'b0) begin
      if (p_csb) begin
        cur_low = 0; cur_rises = 0; cur_mosi = '0;
        per_ok = 1'b1; k = 0; miso = slave_word[W-1];
        if (gap_track > 0) begin
          if (hi < gmin) gmin = hi;
          if (hi > gmax) gmax = hi;
        end
        gap_track++;
      end
      cur_low++;
      if (sclk && !p_sclk) begin
        if (cur_rises > 0 && cyc - last_rise != 2 * CD) per_ok = 1'b0;
        last_rise = cyc;
        cur_rises++;
        cur_mosi = {cur_mosi[W-2:0], mosi};
      end
      if (!sclk && p_sclk) begin
        k++;
        if (k < W) miso = slave_word[W-1-k];
      end
    end else begin
      if (!p_csb) begin
        f_low = cur_low; f_rises = cur_rises;
        f_mosi = cur_mosi; f_per = per_ok; hi = 0;
      end
      hi++;
      if (sclk === 1'b1 || mosi === 1'b1) idle_bad++;
    end
    if (done === 1'b1) done_cnt++;
    p_csb = (csb === 1'b0) ? 1'b0 : 1'b1;
    p_sclk = (sclk === 1'b1);
    cyc++;
  end

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("done_timeout", done, 1'b1);
  endtask

  task automatic do_frame(input logic [W-1:0] d, input logic [W-1:0] w);
    int base = done_cnt;
    tx_data = d;
    slave_word = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    tx_data = W'($urandom);
    check("busy_after_start", busy, 1'b1);
    wait_done();
    check("csb_low_cycles", f_low, 100);
    check("sclk_rises", f_rises, W);
    check("mosi_bits", f_mosi, d);
    check("sclk_period", f_per, 1'b1);
    check("rx_data", rx_data, exp_rx(w));
    check("done_count", done_cnt - base, 1);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("rx_hold", rx_data, exp_rx(w));
  endtask

  initial begin
    int base, n;
    logic [W-1:0] d, w;
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_csb", csb, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_data, '0);
    rst = 1'b0;

    do_frame(24'h0000B8, W'($urandom));
    do_frame(24'hA5C33C, 24'hA5C33C);
    repeat (6) do_frame(W'($urandom), W'($urandom));

    // start held high: three back-to-back frames
    base = done_cnt;
    tx_data = 24'h123456;
    slave_word = W'($urandom);
    gap_track = 0; gmin = 999; gmax = 0;
    start = 1'b1;
    n = 0;
    while (gap_track < 3 && n < 1000) begin tick(); n++; end
    start = 1'b0;
    n = 0;
    while (done_cnt - base < 3 && n < 1000) begin tick(); n++; end
    repeat (20) tick();
    check("b2b_frames", gap_track, 3);
    check("b2b_dones", done_cnt - base, 3);
    check("b2b_gap_min", gmin, 5);
    check("b2b_gap_max", gmax, 5);
    check("b2b_mosi", f_mosi, 24'h123456);
    check("b2b_rx", rx_data, exp_rx(slave_word));
    check("b2b_idle", busy, 1'b0);

    // start pulse during bit 10 must be dropped
    base = done_cnt;
    d = W'($urandom);
    w = W'($urandom);
    tx_data = d;
    slave_word = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cur_rises < 10 && n < 500) begin tick(); n++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check("ign_mosi", f_mosi, d);
    check("ign_rx", rx_data, exp_rx(w));
    repeat (60) tick();
    check("ign_done_count", done_cnt - base, 1);
    check("ign_busy", busy, 1'b0);

    // reset during bit 12 aborts without done
    base = done_cnt;
    tx_data = W'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cur_rises < 12 && n < 500) begin tick(); n++; end
    #2 rst = 1'b1;
    #1;
    check("arst_csb", csb, 1'b1);
    check("arst_sclk", sclk, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_rx", rx_data, '0);
    tick();
    tick();
    rst = 1'b0;
    check("arst_no_done", done_cnt - base, 0);
    do_frame(W'($urandom), W'($urandom));
    check("arst_done_total", done_cnt - base, 1);

    // 8-bit, single-cycle half-period build with loopback
    begin
      int lo = 0, r = 0, last = 0, sd = 0;
      logic [7:0] bits = '0;
      logic pok = 1'b1, p = 1'b0;
      s_tx = 8'h81;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (!s_csb) lo++;
        if (s_sclk && !p) begin
          if (r > 0 && i - last != 2) pok = 1'b0;
          last = i;
          r++;
          bits = {bits[6:0], s_mosi};
        end
        if (s_done) sd++;
        p = s_sclk;
        tick();
      end
      check("w8_csb_low", lo, 20);
      check("w8_rises", r, 8);
      check("w8_mosi", bits, 8'h81);
      check("w8_period", pok, 1'b1);
      check("w8_done", sd, 1);
      check("w8_rx", s_rx, exp_rx(64'h81));
    end

    check("idle_lines_quiet", idle_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
